// File: rtl/sys_pkg.sv
// Shared SRAM address width and the address serializer FSM state encoding.
package sys_pkg;

  localparam int unsigned SRAM_ADDR_WIDTH = 21;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT_LO = 3'd1,
    SHIFT_HI = 3'd2,
    INC_LO   = 3'd3,
    INC_HI   = 3'd4,
    FINISH   = 3'd5
  } state_t;

endpackage

// File: rtl/addr_shift_tx.sv
// Serializes a parallel SRAM address MSB-first into an external shift register
// at clk/2, or pulses the external address counter once.
module addr_shift_tx
  import sys_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = SRAM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  incr,
  output logic                  busy,
  output logic                  done,
  output logic                  si,
  output logic                  sreg_en_n,
  output logic                  sreg_clk,
  output logic                  counter_n
);

  localparam int unsigned      CNT_W    = (ADDR_WIDTH > 1) ? $clog2(ADDR_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(ADDR_WIDTH - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic busy_q, busy_d;
  logic done_q, done_d;
  logic si_q, si_d;
  logic sreg_en_n_q, sreg_en_n_d;
  logic sreg_clk_q, sreg_clk_d;
  logic counter_n_q, counter_n_d;

  // State, datapath and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      si_q        <= 1'b0;
      sreg_en_n_q <= 1'b1;
      sreg_clk_q  <= 1'b0;
      counter_n_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      si_q        <= si_d;
      sreg_en_n_q <= sreg_en_n_d;
      sreg_clk_q  <= sreg_clk_d;
      counter_n_q <= counter_n_d;
    end
  end

  // Next-state and datapath; start/incr only matter in IDLE, start has priority
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT_LO;
          sreg_d  = addr;
          cnt_d   = '0;
        end else if (incr) begin
          state_d = INC_LO;
        end
      end
      SHIFT_LO: state_d = SHIFT_HI;
      SHIFT_HI: begin
        sreg_d  = sreg_q << 1;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = (cnt_q == LAST_BIT) ? FINISH : SHIFT_LO;
      end
      INC_LO:   state_d = INC_HI;
      INC_HI:   state_d = FINISH;
      FINISH:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs decoded from the upcoming state so the registers line up with it
  always_comb begin
    busy_d      = 1'b1;
    done_d      = 1'b0;
    si_d        = 1'b0;
    sreg_en_n_d = 1'b1;
    sreg_clk_d  = 1'b0;
    counter_n_d = 1'b1;
    case (state_d)
      IDLE: busy_d = 1'b0;
      SHIFT_LO: begin
        sreg_en_n_d = 1'b0;
        si_d        = sreg_d[ADDR_WIDTH-1];
      end
      SHIFT_HI: begin
        sreg_en_n_d = 1'b0;
        sreg_clk_d  = 1'b1;
        si_d        = si_q;
      end
      INC_LO: counter_n_d = 1'b0;
      INC_HI: begin
        counter_n_d = 1'b0;
        sreg_clk_d  = 1'b1;
      end
      FINISH:  done_d = 1'b1;
      default: busy_d = 1'b0;
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign si        = si_q;
  assign sreg_en_n = sreg_en_n_q;
  assign sreg_clk  = sreg_clk_q;
  assign counter_n = counter_n_q;

endmodule

// File: tb/tb_addr_shift_tx.sv
// Directed bench for addr_shift_tx: expected serial bits are queued at start
// and popped on every observed sreg_clk rising edge.
module tb_addr_shift_tx;

  localparam int unsigned AW = 21;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic [AW-1:0] addr;
  logic          incr;
  logic          busy;
  logic          done;
  logic          si;
  logic          sreg_en_n;
  logic          sreg_clk;
  logic          counter_n;

  addr_shift_tx #(.ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .addr      (addr),
    .incr      (incr),
    .busy      (busy),
    .done      (done),
    .si        (si),
    .sreg_en_n (sreg_en_n),
    .sreg_clk  (sreg_clk),
    .counter_n (counter_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   passes = 0;
  int   fails  = 0;
  logic exp_q[$];
  logic prev_sclk = 1'b0;
  logic si_lo = 1'b0;
  int   shift_edges, inc_edges, done_cnt, busy_cnt, cn_low, en_low;
  int   done_edge;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_si"}, 32'(si), 32'd0);
    check({tag, "_en_n"}, 32'(sreg_en_n), 32'd1);
    check({tag, "_sclk"}, 32'(sreg_clk), 32'd0);
    check({tag, "_cnt_n"}, 32'(counter_n), 32'd1);
  endtask

  // Called once per negedge: scoreboard pop on each sreg_clk rising edge
  task automatic sample();
    logic e;
    if (sreg_clk && !prev_sclk) begin
      if (!sreg_en_n) begin
        shift_edges++;
        if (exp_q.size() == 0) begin
          check("si_unexpected_bit", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("si_bit", 32'(si), 32'(e));
        end
        check("si_hold", 32'(si), 32'(si_lo));
      end else begin
        inc_edges++;
        check("inc_counter_n", 32'(counter_n), 32'd0);
      end
    end
    if (!sreg_clk) si_lo = si;
    if (!counter_n) cn_low++;
    if (!sreg_en_n) en_low++;
    if (done) done_cnt++;
    if (busy) busy_cnt++;
    prev_sclk = sreg_clk;
  endtask

  task automatic push_bits(input logic [AW-1:0] a);
    for (int b = AW - 1; b >= 0; b--) exp_q.push_back(a[b]);
  endtask

  // Entered just after a negedge; returns at the first IDLE negedge after done
  task automatic run_op(input logic s, input logic i, input logic [AW-1:0] a,
                        input int restart_at);
    shift_edges = 0; inc_edges = 0; done_cnt = 0; busy_cnt = 0;
    cn_low = 0; en_low = 0; done_edge = -1;
    if (s) push_bits(a);
    start = s; incr = i; addr = a;
    @(posedge clk);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      start = 1'b0; incr = 1'b0;
      if (k == restart_at) begin
        start = 1'b1;
        addr  = '0;
      end
      sample();
      if (done && done_edge < 0) done_edge = k;
      if (!busy && done_edge >= 0) break;
      @(posedge clk);
    end
  endtask

  task automatic check_transfer(input string tag);
    check({tag, "_done_edge"}, 32'(done_edge), 32'd42);
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check({tag, "_busy_cyc"}, 32'(busy_cnt), 32'd43);
    check({tag, "_shift_edges"}, 32'(shift_edges), 32'd21);
    check({tag, "_en_low"}, 32'(en_low), 32'd42);
    check({tag, "_cn_low"}, 32'(cn_low), 32'd0);
    check({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; incr = 1'b0; addr = '0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("post_reset");

    // Reference pattern, MSB first
    run_op(1'b1, 1'b0, 21'h1A5A5A, -1);
    check_transfer("xfer_1a5a5a");
    check_idle("after_xfer");

    // Counter increment
    run_op(1'b0, 1'b1, '0, -1);
    check("inc_done_edge", 32'(done_edge), 32'd2);
    check("inc_done_cnt", 32'(done_cnt), 32'd1);
    check("inc_busy_cyc", 32'(busy_cnt), 32'd3);
    check("inc_sclk_edges", 32'(inc_edges), 32'd1);
    check("inc_cn_low", 32'(cn_low), 32'd2);
    check("inc_en_low", 32'(en_low), 32'd0);
    check("inc_shift_edges", 32'(shift_edges), 32'd0);

    // start wins over incr
    run_op(1'b1, 1'b1, 21'h000001, -1);
    check_transfer("start_incr");

    // Restart request and addr change mid-transfer are ignored
    run_op(1'b1, 1'b0, 21'h1A5A5A, 10);
    check_transfer("restart_ignored");
    repeat (3) begin
      @(negedge clk);
      check("no_queued_start", 32'(busy), 32'd0);
    end

    // Reset during a transfer aborts it with no done
    shift_edges = 0; done_cnt = 0; busy_cnt = 0; cn_low = 0; en_low = 0;
    push_bits(21'h1A5A5A);
    start = 1'b1; addr = 21'h1A5A5A;
    @(posedge clk);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      sample();
      if (k < 19) @(posedge clk);
    end
    check("abort_pre_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check_idle("abort");
    check("abort_no_done", 32'(done_cnt), 32'd0);
    exp_q.delete();
    prev_sclk = 1'b0;
    @(negedge clk);
    check_idle("abort_held");
    reset_n = 1'b1;
    @(negedge clk);

    run_op(1'b1, 1'b0, 21'h100000, -1);
    check_transfer("after_abort");

    // Back-to-back: new start in the IDLE cycle right after done
    run_op(1'b1, 1'b0, 21'h0F0F0F, -1);
    check_transfer("b2b_first");
    run_op(1'b1, 1'b0, 21'h155555, -1);
    check_transfer("b2b_second");

    // A couple of random addresses
    repeat (2) begin
      run_op(1'b1, 1'b0, AW'($urandom), -1);
      check_transfer("rand");
    end

    @(negedge clk);
    check_idle("final");

    $display("%0d/%0d checks passed", passes, passes + fails);
    $finish;
  end

endmodule
